// File: rtl/piso_shift_out_4bit.sv
// Parallel-in serial-out shifter with valid/ready handshakes on both sides.
// A word is captured from Din in IDLE and then shifted out one bit per
// accepted serial transfer. Done pulses for one cycle after the last bit.
module piso_shift_out_4bit #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Din,
   input  logic             Ld_valid,
   output logic             Ld_ready,
   output logic             Sout,
   output logic             Sout_valid,
   input  logic             Sout_ready,
   output logic             Done,
   output logic             Busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    count, count_n;
   logic             sout_n, sout_valid_n, done_n, busy_n;

   // Bit presented on the serial output for a given shift register value
   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Shift one position toward the output end, zero filling the far end
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   // Load acceptance is decoded directly from the state
   assign Ld_ready = (state == IDLE);

   // State register and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         shreg      <= '0;
         count      <= '0;
         Sout       <= 1'b0;
         Sout_valid <= 1'b0;
         Done       <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         count      <= count_n;
         Sout       <= sout_n;
         Sout_valid <= sout_valid_n;
         Done       <= done_n;
         Busy       <= busy_n;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      count_n = count;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (Ld_valid) begin
               shreg_n = Din;
               count_n = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (Sout_valid && Sout_ready) begin
               shreg_n = shift_one(shreg);
               if (count == CW'(WIDTH - 1)) begin
                  count_n = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  count_n = count + CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      sout_valid_n = (state_n == SHIFT);
      busy_n       = (state_n == SHIFT);
      sout_n       = (state_n == SHIFT) ? out_bit(shreg_n) : 1'b0;
   end

endmodule

// File: tb/tb_piso_shift_out_4bit.sv
// Self-checking bench for piso_shift_out_4bit: scoreboard of expected serial
// bits per instance, table-driven words plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_piso_shift_out_4bit;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;
   logic RST;

   // Instance a: WIDTH=4, LSB first
   logic [3:0] a_din;
   logic a_ld_valid, a_ld_ready, a_sout, a_sout_valid, a_sout_ready, a_done, a_busy;
   // Instance b: WIDTH=4, MSB first
   logic [3:0] b_din;
   logic b_ld_valid, b_ld_ready, b_sout, b_sout_valid, b_sout_ready, b_done, b_busy;
   // Instance c: WIDTH=8, MSB first
   logic [7:0] c_din;
   logic c_ld_valid, c_ld_ready, c_sout, c_sout_valid, c_sout_ready, c_done, c_busy;

   piso_shift_out_4bit #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_a (
      .CLK(CLK), .RST(RST), .Din(a_din), .Ld_valid(a_ld_valid), .Ld_ready(a_ld_ready),
      .Sout(a_sout), .Sout_valid(a_sout_valid), .Sout_ready(a_sout_ready),
      .Done(a_done), .Busy(a_busy));
   piso_shift_out_4bit #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_b (
      .CLK(CLK), .RST(RST), .Din(b_din), .Ld_valid(b_ld_valid), .Ld_ready(b_ld_ready),
      .Sout(b_sout), .Sout_valid(b_sout_valid), .Sout_ready(b_sout_ready),
      .Done(b_done), .Busy(b_busy));
   piso_shift_out_4bit #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
      .CLK(CLK), .RST(RST), .Din(c_din), .Ld_valid(c_ld_valid), .Ld_ready(c_ld_ready),
      .Sout(c_sout), .Sout_valid(c_sout_valid), .Sout_ready(c_sout_ready),
      .Done(c_done), .Busy(c_busy));

   int nchk = 0;
   int nfail = 0;
   logic qa[$];
   logic qb[$];
   logic qc[$];
   int a_done_cnt = 0;
   int b_done_cnt = 0;
   int c_done_cnt = 0;
   logic a_prev_stall = 1'b0;
   logic a_prev_sout = 1'b0;
   logic a_exp, b_exp, c_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor for instance a: bit order, stall hold, idle zero, Done count
   always @(negedge CLK) begin
      if (RST) begin
         a_prev_stall = 1'b0;
      end else begin
         if (a_prev_stall) begin
            chk("a_stall_valid", a_sout_valid, 1);
            chk("a_stall_hold", a_sout, a_prev_sout);
         end
         if (!a_sout_valid) chk("a_idle_zero", a_sout, 0);
         if (a_sout_valid && a_sout_ready) begin
            if (qa.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL a_unexpected_bit: got %0b, expected none", a_sout);
            end else begin
               a_exp = qa.pop_front();
               chk("a_bit", a_sout, a_exp);
            end
         end
         if (a_done) a_done_cnt++;
         a_prev_stall = a_sout_valid && !a_sout_ready;
         a_prev_sout  = a_sout;
      end
   end

   // Scoreboard monitor for instances b and c
   always @(negedge CLK) begin
      if (!RST) begin
         if (b_sout_valid && b_sout_ready) begin
            if (qb.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL b_unexpected_bit: got %0b, expected none", b_sout);
            end else begin
               b_exp = qb.pop_front();
               chk("b_bit", b_sout, b_exp);
            end
         end
         if (c_sout_valid && c_sout_ready) begin
            if (qc.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL c_unexpected_bit: got %0b, expected none", c_sout);
            end else begin
               c_exp = qc.pop_front();
               chk("c_bit", c_sout, c_exp);
            end
         end
         if (b_done) b_done_cnt++;
         if (c_done) c_done_cnt++;
      end
   end

   // seq lists the serial bits in send order, first bit in seq[3]
   typedef struct {
      logic [3:0] din;
      logic [3:0] seq;
      logic [7:0] pat;     // Sout_ready per cycle after load, bit 0 first
      int         cyc;     // cycles from load edge until Done is seen
      bit         busy_ld; // hold Ld_valid with Din=F while shifting
   } vec_t;

   vec_t vt[5];

   // Wait for Done on instance a, bounded; returns cycles waited
   task automatic wait_done_a(input string tag, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(posedge CLK); #1;
         n++;
         if (a_done) seen = 1'b1;
      end
      if (!seen) begin
         nchk++; nfail++;
         $display("FAIL %s_timeout: got no Done, expected Done within 40 cycles", tag);
      end
   endtask

   task automatic run_a(input vec_t v, input string tag);
      int d0, n;
      bit seen;
      d0 = a_done_cnt;
      a_din = v.din;
      a_ld_valid = 1'b1;
      chk({tag, "_ld_ready_pre"}, a_ld_ready, 1);
      for (int k = 3; k >= 0; k--) qa.push_back(v.seq[k]);
      @(posedge CLK); #1;
      a_ld_valid = v.busy_ld;
      if (v.busy_ld) a_din = 4'hF;
      chk({tag, "_busy_after_load"}, a_busy, 1);
      chk({tag, "_valid_after_load"}, a_sout_valid, 1);
      chk({tag, "_ld_ready_shift"}, a_ld_ready, 0);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         a_sout_ready = (n < 8) ? v.pat[n] : 1'b1;
         @(posedge CLK); #1;
         n++;
         if (a_done) seen = 1'b1;
      end
      if (!seen) begin
         nchk++; nfail++;
         $display("FAIL %s_timeout: got no Done, expected Done within 40 cycles", tag);
      end
      chk({tag, "_cycles"}, n, v.cyc);
      chk({tag, "_ld_ready_done"}, a_ld_ready, 1);
      chk({tag, "_valid_done"}, a_sout_valid, 0);
      chk({tag, "_busy_done"}, a_busy, 0);
      a_ld_valid = 1'b0;
      a_sout_ready = 1'b1;
      @(posedge CLK); #1;
      chk({tag, "_done_pulse"}, a_done, 0);
      chk({tag, "_idle_after"}, a_busy, 0);
      chk({tag, "_done_count"}, a_done_cnt - d0, 1);
      chk({tag, "_queue_empty"}, qa.size(), 0);
   endtask

   initial begin
      int n, d0;
      vt[0] = '{4'b1011, 4'b1101, 8'hFF, 4, 1'b0};
      vt[1] = '{4'b1001, 4'b1001, 8'hE9, 7, 1'b0};
      vt[2] = '{4'b0101, 4'b1010, 8'hFF, 4, 1'b1};
      vt[3] = '{4'b0000, 4'b0000, 8'hFF, 4, 1'b0};
      vt[4] = '{4'b1110, 4'b0111, 8'h55, 7, 1'b0};

      RST = 1'b1;
      a_din = '0; a_ld_valid = 1'b0; a_sout_ready = 1'b1;
      b_din = '0; b_ld_valid = 1'b0; b_sout_ready = 1'b1;
      c_din = '0; c_ld_valid = 1'b0; c_sout_ready = 1'b1;
      #2;
      chk("rst_ld_ready", a_ld_ready, 1);
      chk("rst_sout_valid", a_sout_valid, 0);
      chk("rst_sout", a_sout, 0);
      chk("rst_done", a_done, 0);
      chk("rst_busy", a_busy, 0);
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Table-driven words on the LSB-first instance
      foreach (vt[i]) run_a(vt[i], $sformatf("vec%0d", i));

      // Reset in the middle of a word, then a clean word afterwards
      a_din = 4'b1011;
      a_ld_valid = 1'b1;
      qa.push_back(1'b1); qa.push_back(1'b1); qa.push_back(1'b0); qa.push_back(1'b1);
      @(posedge CLK); #1;
      a_ld_valid = 1'b0;
      a_sout_ready = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("midrst_bits_sent", qa.size(), 2);
      RST = 1'b1;
      #1;
      chk("midrst_valid", a_sout_valid, 0);
      chk("midrst_ld_ready", a_ld_ready, 1);
      chk("midrst_busy", a_busy, 0);
      chk("midrst_sout", a_sout, 0);
      qa.delete();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      run_a('{4'b0110, 4'b0110, 8'hFF, 4, 1'b0}, "post_rst");

      // Back-to-back words with Ld_valid held high throughout
      d0 = a_done_cnt;
      a_din = 4'hC;
      a_ld_valid = 1'b1;
      a_sout_ready = 1'b1;
      qa.push_back(1'b0); qa.push_back(1'b0); qa.push_back(1'b1); qa.push_back(1'b1);
      qa.push_back(1'b1); qa.push_back(1'b1); qa.push_back(1'b0); qa.push_back(1'b0);
      @(posedge CLK); #1;
      a_din = 4'h3;
      wait_done_a("b2b_w1", n);
      chk("b2b_w1_cycles", n, 4);
      chk("b2b_ld_ready_done", a_ld_ready, 1);
      @(posedge CLK); #1;
      chk("b2b_w2_captured", a_busy, 1);
      chk("b2b_w2_valid", a_sout_valid, 1);
      a_ld_valid = 1'b0;
      wait_done_a("b2b_w2", n);
      chk("b2b_w2_cycles", n, 4);
      @(posedge CLK); #1;
      chk("b2b_done_count", a_done_cnt - d0, 2);
      chk("b2b_queue_empty", qa.size(), 0);

      // MSB-first instances: 4-bit 1011 and 8-bit A5
      b_din = 4'b1011;
      b_ld_valid = 1'b1;
      c_din = 8'hA5;
      c_ld_valid = 1'b1;
      qb.push_back(1'b1); qb.push_back(1'b0); qb.push_back(1'b1); qb.push_back(1'b1);
      qc.push_back(1'b1); qc.push_back(1'b0); qc.push_back(1'b1); qc.push_back(1'b0);
      qc.push_back(1'b0); qc.push_back(1'b1); qc.push_back(1'b0); qc.push_back(1'b1);
      @(posedge CLK); #1;
      b_ld_valid = 1'b0;
      c_ld_valid = 1'b0;
      n = 0;
      while (!c_done && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("msb8_cycles", n, 8);
      @(posedge CLK); #1;
      chk("msb4_queue_empty", qb.size(), 0);
      chk("msb8_queue_empty", qc.size(), 0);
      chk("msb4_done_count", b_done_cnt, 1);
      chk("msb8_done_count", c_done_cnt, 1);
      chk("msb4_idle", b_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
